// File: rtl/mtr_drv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mtr_drv : dual-motor complementary PWM generator with dead-time and      |
// |           period-aligned (double-buffered) duty loading.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mtr_drv #(
  parameter logic [10:0] NONOVERLAP = 11'd32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  input  logic        en,
  output logic        lft_pwm1,
  output logic        lft_pwm2,
  output logic        rght_pwm1,
  output logic        rght_pwm2,
  output logic        pwm_synch
);

  localparam logic [10:0] C_CNT_MAX  = 11'h7FF;
  localparam logic [10:0] C_DUTY_RST = 11'h400;

  logic [10:0] r_cnt;
  logic [10:0] r_lft_duty;
  logic [10:0] r_rght_duty;
  logic        w_wrap;
  logic [11:0] w_lft_off;
  logic [11:0] w_rght_off;
  logic        w_lft_pwm1;
  logic        w_lft_pwm2;
  logic        w_rght_pwm1;
  logic        w_rght_pwm2;

  assign w_wrap = (r_cnt == C_CNT_MAX);

  // Widened to 12 bits so a large duty pushes the pwm2 edge past the period
  // instead of wrapping to an early turn-on.
  assign w_lft_off  = {1'b0, r_lft_duty}  + {1'b0, NONOVERLAP};
  assign w_rght_off = {1'b0, r_rght_duty} + {1'b0, NONOVERLAP};

  always_comb begin
    w_lft_pwm1  = en && (r_cnt >= NONOVERLAP) && (r_cnt < r_lft_duty);
    w_lft_pwm2  = en && ({1'b0, r_cnt} >= w_lft_off);
    w_rght_pwm1 = en && (r_cnt >= NONOVERLAP) && (r_cnt < r_rght_duty);
    w_rght_pwm2 = en && ({1'b0, r_cnt} >= w_rght_off);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 11'd0;
      r_lft_duty  <= C_DUTY_RST;
      r_rght_duty <= C_DUTY_RST;
    end else begin
      r_cnt <= r_cnt + 11'd1;
      // Offset-binary conversion: flipping the sign bit adds 1024.
      if (w_wrap) begin
        r_lft_duty  <= {~lft_spd[10],  lft_spd[9:0]};
        r_rght_duty <= {~rght_spd[10], rght_spd[9:0]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_pwm1  <= 1'b0;
      lft_pwm2  <= 1'b0;
      rght_pwm1 <= 1'b0;
      rght_pwm2 <= 1'b0;
      pwm_synch <= 1'b0;
    end else begin
      lft_pwm1  <= w_lft_pwm1;
      lft_pwm2  <= w_lft_pwm2;
      rght_pwm1 <= w_rght_pwm1;
      rght_pwm2 <= w_rght_pwm2;
      pwm_synch <= w_wrap;
    end
  end

endmodule
`default_nettype wire
